uart_tx_buffer: RTL and testbench

- Byte FIFO plus transmit sequencer directly upstream of the UART sender.
- Absorbs bursts of bytes written by the CPU peripheral bus and hands them to the sender one at a time.
- Drives the sender's data, trigger and enable inputs; paces itself from the sender's state and finish outputs.
- Guarantees tx_data is stable for the whole frame and enforces an inter-frame idle gap.

---
 rtl/uart_tx_buffer_if.sv | 42 ++++
 rtl/uart_tx_buffer.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buffer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_if.sv
// Bus/sender signal bundle for uart_tx_buffer. Defining UART_TX_BUF_OVF_CNT_EN
// adds the ovf_count field and routes it through both modports.
interface uart_tx_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                clr_overflow;
  logic [7:0]          tx_data;
  logic                tx_trigger;
  logic                tx_enable;
  logic                tx_state;
  logic                tx_finish;
  logic                idle;
`ifdef UART_TX_BUF_OVF_CNT_EN
  logic [7:0]          ovf_count;

  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_state, tx_finish,
    output full, empty, count, overflow, tx_data, tx_trigger, tx_enable, idle, ovf_count
  );

  modport master (
    output wr_en, wr_data, clr_overflow, tx_state, tx_finish,
    input  full, empty, count, overflow, tx_data, tx_trigger, tx_enable, idle, ovf_count
  );
`else
  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_state, tx_finish,
    output full, empty, count, overflow, tx_data, tx_trigger, tx_enable, idle
  );

  modport master (
    output wr_en, wr_data, clr_overflow, tx_state, tx_finish,
    input  full, empty, count, overflow, tx_data, tx_trigger, tx_enable, idle
  );
`endif
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus transmit sequencer feeding the UART sender one frame at a time.
// Optional UART_TX_BUF_OVF_CNT_EN adds a saturating dropped-write counter (ovf_count).
module uart_tx_buffer #(
  parameter int DEPTH_LOG2    = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 1024
) (
  input  logic            sysclk,
  input  logic            reset,
  uart_tx_buffer_if.slave bus
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int TIMER_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TIMER_W-1:0]  START_LAST = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]  GAP_LAST   = TIMER_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_START,
    ST_WAIT_FIN,
    ST_GAP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            tx_data;
  logic                  overflow;
  logic [TIMER_W-1:0]    timer;
  logic                  finish_q;

  logic full, empty, wr_accept, wr_drop;
  logic pop, trigger, enable, timer_clr;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign wr_accept = bus.wr_en && !full;
  assign wr_drop   = bus.wr_en && full;

  always_ff @(posedge sysclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Sequencer: LOAD pops exactly once per byte; re-kicks after a start timeout reuse tx_data.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    trigger   = 1'b0;
    enable    = 1'b0;
    timer_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        pop       = 1'b1;
        state_nxt = ST_KICK;
      end
      ST_KICK: begin
        trigger   = 1'b1;
        enable    = 1'b1;
        timer_clr = 1'b1;
        state_nxt = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        enable = 1'b1;
        if (bus.tx_state)             state_nxt = ST_WAIT_FIN;
        else if (timer == START_LAST) state_nxt = ST_KICK;
      end
      ST_WAIT_FIN: begin
        enable = 1'b1;
        if (bus.tx_finish && !finish_q) begin
          timer_clr = 1'b1;
          state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (wr_accept) mem[wr_ptr] <= bus.wr_data;
  end

  // Occupancy and pointers; a simultaneous write and pop leaves count unchanged.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
      timer    <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= bus.tx_finish;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_drop)               overflow <= 1'b1;
      else if (bus.clr_overflow) overflow <= 1'b0;
      if (timer_clr) timer <= '0;
      else           timer <= timer + 1'b1;
    end
  end

`ifdef UART_TX_BUF_OVF_CNT_EN
  logic [7:0] ovf_count;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      ovf_count <= 8'h00;
    end else if (wr_drop) begin
      if (bus.clr_overflow)         ovf_count <= 8'h01;
      else if (ovf_count != 8'hFF)  ovf_count <= ovf_count + 8'h01;
    end else if (bus.clr_overflow) begin
      ovf_count <= 8'h00;
    end
  end

  assign bus.ovf_count = ovf_count;
`endif

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count;
  assign bus.overflow   = overflow;
  assign bus.tx_data    = tx_data;
  assign bus.tx_trigger = trigger;
  assign bus.tx_enable  = enable;
  assign bus.idle       = (state == ST_IDLE) && empty;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: vector table for fill/overflow plus hand-written
// sequences for latency, ordering, start timeout, finish edge and mid-frame reset.
module tb_uart_tx_buffer;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  always #5 sysclk = ~sysclk;

  uart_tx_buffer_if #(.DEPTH_LOG2(4)) bus ();

  uart_tx_buffer #(
    .DEPTH_LOG2(4),
    .GAP_CYCLES(16),
    .START_TIMEOUT(1024)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge sysclk) cyc++;

  // Sender model: 0 = silent, 1 = busy 5 cycles after trigger then finish pulse, 3 = manual
  int   smode = 0;
  int   scnt  = 0;
  logic mdl_state  = 1'b0;
  logic mdl_finish = 1'b0;
  logic man_state  = 1'b0;
  logic man_finish = 1'b0;
  int   trig_cyc[$];
  logic [7:0] trig_data[$];

  assign bus.tx_state  = (smode == 3) ? man_state  : mdl_state;
  assign bus.tx_finish = (smode == 3) ? man_finish : mdl_finish;

  always @(negedge sysclk) begin
    if (smode == 1 && bus.tx_trigger === 1'b1) begin
      trig_cyc.push_back(cyc);
      trig_data.push_back(bus.tx_data);
    end
    if (smode != 1 || reset) begin
      mdl_state  = 1'b0;
      mdl_finish = 1'b0;
      scnt       = 0;
    end else if (scnt == 0) begin
      if (bus.tx_trigger === 1'b1) scnt = 1;
    end else begin
      scnt++;
      if (scnt == 6) mdl_state = 1'b1;
      if (scnt == 26) begin
        mdl_state  = 1'b0;
        mdl_finish = 1'b1;
      end
      if (scnt == 28) begin
        mdl_finish = 1'b0;
        scnt       = 0;
      end
    end
  end

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       clr;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       trig;
    logic [7:0] txd;
    int         ocnt;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic clr);
    bus.wr_en        = we;
    bus.wr_data      = wd;
    bus.clr_overflow = clr;
    tick();
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.clr_overflow = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int bound);
    int n;
    n = 0;
    while (bus.idle !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checkOutput(name, {31'd0, bus.idle}, 32'd1);
  endtask

  initial begin
    int n;
    int kick0;
    int found;
    int ntrig;

    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.clr_overflow = 1'b0;

    for (int i = 0; i < 21; i++) begin
      vecs[i].clr   = 1'b0;
      vecs[i].empty = 1'b0;
      if (i <= 16) begin
        vecs[i].we   = 1'b1;
        vecs[i].wd   = 8'(8'h20 + i);
        vecs[i].cnt  = (i < 2) ? i + 1 : i;
        vecs[i].full = (i == 16);
        vecs[i].ovf  = 1'b0;
        vecs[i].ocnt = 0;
      end else if (i <= 19) begin
        vecs[i].we   = 1'b1;
        vecs[i].wd   = 8'hEE;
        vecs[i].cnt  = 16;
        vecs[i].full = 1'b1;
        vecs[i].ovf  = 1'b1;
        vecs[i].ocnt = i - 16;
      end else begin
        vecs[i].we   = 1'b0;
        vecs[i].wd   = 8'h00;
        vecs[i].clr  = 1'b1;
        vecs[i].cnt  = 16;
        vecs[i].full = 1'b1;
        vecs[i].ovf  = 1'b0;
        vecs[i].ocnt = 0;
      end
      vecs[i].trig = (i == 2);
      vecs[i].txd  = (i >= 2) ? 8'h20 : 8'h00;
    end

    // Reset state
    smode = 0;
    reset = 1'b1;
    tick();
    checkOutput("rst_count",    32'(bus.count), 32'd0);
    checkOutput("rst_empty",    {31'd0, bus.empty}, 32'd1);
    checkOutput("rst_full",     {31'd0, bus.full}, 32'd0);
    checkOutput("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    checkOutput("rst_tx_data",  32'(bus.tx_data), 32'h00);
    checkOutput("rst_trigger",  {31'd0, bus.tx_trigger}, 32'd0);
    checkOutput("rst_enable",   {31'd0, bus.tx_enable}, 32'd0);
    checkOutput("rst_idle",     {31'd0, bus.idle}, 32'd1);
`ifdef UART_TX_BUF_OVF_CNT_EN
    checkOutput("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
`endif
    doReset();

    // Fill with a silent sender, overflow by 3, then clear
    kick0 = 0;
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].clr);
      checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      checkOutput($sformatf("vec%0d_full", i), {31'd0, bus.full}, {31'd0, vecs[i].full});
      checkOutput($sformatf("vec%0d_empty", i), {31'd0, bus.empty}, {31'd0, vecs[i].empty});
      checkOutput($sformatf("vec%0d_overflow", i), {31'd0, bus.overflow}, {31'd0, vecs[i].ovf});
      checkOutput($sformatf("vec%0d_trigger", i), {31'd0, bus.tx_trigger}, {31'd0, vecs[i].trig});
      checkOutput($sformatf("vec%0d_tx_data", i), 32'(bus.tx_data), 32'(vecs[i].txd));
`ifdef UART_TX_BUF_OVF_CNT_EN
      checkOutput($sformatf("vec%0d_ovf_count", i), 32'(bus.ovf_count), 32'(vecs[i].ocnt));
`endif
      if (i == 2) kick0 = cyc;
    end
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Start timeout: same byte re-kicked every 1025 cycles, no extra pop
    for (int r = 0; r < 2; r++) begin
      found = 0;
      n = 0;
      while (found == 0 && n < 1100) begin
        if (bus.tx_trigger === 1'b1) found = 1;
        else begin
          tick();
          n++;
        end
      end
      checkOutput($sformatf("retrig%0d_seen", r), 32'(found), 32'd1);
      checkOutput($sformatf("retrig%0d_period", r), 32'(cyc - kick0), 32'd1025);
      checkOutput($sformatf("retrig%0d_tx_data", r), 32'(bus.tx_data), 32'h20);
      checkOutput($sformatf("retrig%0d_count", r), 32'(bus.count), 32'd16);
      kick0 = cyc;
      tick();
      checkOutput($sformatf("retrig%0d_single", r), {31'd0, bus.tx_trigger}, 32'd0);
    end

    // Single byte latency and inter-frame gap
    smode = 1;
    doReset();
    trig_cyc.delete();
    trig_data.delete();
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("lat_empty_n1", {31'd0, bus.empty}, 32'd0);
    checkOutput("lat_trig_n1",  {31'd0, bus.tx_trigger}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lat_trig_n2",  {31'd0, bus.tx_trigger}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lat_trig_n3",  {31'd0, bus.tx_trigger}, 32'd1);
    checkOutput("lat_tx_data",  32'(bus.tx_data), 32'hA5);
    n = 0;
    while (bus.idle !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == 25) checkOutput("frame_enable_fin", {31'd0, bus.tx_enable}, 32'd1);
      if (n == 26) checkOutput("frame_enable_gap", {31'd0, bus.tx_enable}, 32'd0);
    end
    checkOutput("frame_idle_delay", 32'(n), 32'd42);
    checkOutput("frame_count", 32'(trig_data.size()), 32'd1);

    // Burst of 16 bytes, emitted in order with fixed frame spacing
    trig_cyc.delete();
    trig_data.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("burst_count_after_writes", 32'(bus.count), 32'd15);
    checkOutput("burst_full_after_writes", {31'd0, bus.full}, 32'd0);
    bus.wr_en = 1'b0;
    n = 0;
    while (!(trig_data.size() == 16 && bus.idle === 1'b1) && n < 1200) begin
      tick();
      n++;
    end
    checkOutput("burst_frames", 32'(trig_data.size()), 32'd16);
    for (int i = 0; i < trig_data.size(); i++) begin
      checkOutput($sformatf("burst_byte%0d", i), 32'(trig_data[i]), 32'(i));
      if (i > 0) checkOutput($sformatf("burst_spacing%0d", i), 32'(trig_cyc[i] - trig_cyc[i-1]), 32'd44);
    end
    checkOutput("burst_count_end", 32'(bus.count), 32'd0);

    // Finish already high on WAIT_FIN entry is not an edge
    smode = 3;
    man_state  = 1'b0;
    man_finish = 1'b1;
    doReset();
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fin_trig", {31'd0, bus.tx_trigger}, 32'd1);
    man_state = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("fin_high_hold", {31'd0, bus.tx_enable}, 32'd1);
    man_finish = 1'b0;
    tick();
    tick();
    checkOutput("fin_low_hold", {31'd0, bus.tx_enable}, 32'd1);
    man_finish = 1'b1;
    tick();
    checkOutput("fin_edge_gap", {31'd0, bus.tx_enable}, 32'd0);
    man_state = 1'b0;
    waitIdle("fin_idle", 100);

    // Reset in WAIT_FIN with 5 bytes queued
    man_finish = 1'b0;
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("mid_count", 32'(bus.count), 32'd5);
    man_state = 1'b1;
    tick();
    tick();
    checkOutput("mid_enable", {31'd0, bus.tx_enable}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    man_state = 1'b0;
    checkOutput("mid_rst_count",   32'(bus.count), 32'd0);
    checkOutput("mid_rst_empty",   {31'd0, bus.empty}, 32'd1);
    checkOutput("mid_rst_enable",  {31'd0, bus.tx_enable}, 32'd0);
    checkOutput("mid_rst_tx_data", 32'(bus.tx_data), 32'h00);
    checkOutput("mid_rst_idle",    {31'd0, bus.idle}, 32'd1);
    ntrig = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.tx_trigger === 1'b1) ntrig++;
    end
    checkOutput("mid_no_triggers", 32'(ntrig), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
